transport_ctrl: RTL and testbench
=================================

TRANSPORT_CTRL -- requirements
Module: transport_ctrl

Interface
REQ-001 Parameter SEEK_BEATS, default 8: beats per fast-forward burst, range 1..15.
REQ-002 Parameter CW, default 4: seek counter width; SHALL satisfy SEEK_BEATS < 2**CW.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 play_button, next_button, prev_button, ff_button, rewind_button  in  1 each  single-cycle pulses from debounced buttons.
REQ-006 song_done  in  1  one-cycle pulse from player at end of song.
REQ-007 beat  in  1  one-cycle pulse per note step from beat generator.
REQ-008 at_start  in  1  high while note address of current song is 0.
REQ-009 play  out  1  high only in PLAY.
REQ-010 seeking  out  1  high in FF or REW.
REQ-011 step_fwd / step_back  out  1 each  note-address increment / decrement strobes.
REQ-012 song  out  2  current song index.
REQ-013 reset_player  out  1  one-cycle player restart pulse.

Function
REQ-014 States: PAUSE, PLAY, FF, REW; plus a 1-bit resume register (PAUSE or PLAY) and a CW-bit seek counter.
REQ-015 Same-cycle event priority: next > prev > song_done > play_button > ff_button > rewind_button; only the highest-priority event is acted on, the rest are dropped.
REQ-016 next: song <= song+1, wrapping 3->0; state <= PAUSE; legal in every state.
REQ-017 prev: song <= song-1, wrapping 0->3; state <= PAUSE; legal in every state.
REQ-018 song_done: song <= song+1 with wrap; next state per REQ-034/035; in FF/REW, state <= resume.
REQ-019 reset_player SHALL be registered, high exactly one cycle, in the cycle after an accepted next, prev or song_done, coincident with the new song value.
REQ-020 PAUSE: play_button -> PLAY; ff_button -> FF with resume <= PAUSE; rewind_button -> REW with resume <= PAUSE.
REQ-021 PLAY: play_button -> PAUSE; ff_button -> FF with resume <= PLAY; rewind_button -> REW with resume <= PLAY.
REQ-022 On entry to FF, seek counter <= SEEK_BEATS.
REQ-023 FF: step_fwd = beat (combinational, same cycle); each beat decrements counter; beat with counter == 1 -> state <= resume.
REQ-024 FF: ff_button -> state <= resume immediately, no further step; rewind_button -> REW, resume unchanged; play_button -> resume <= PAUSE if resume is PLAY, else PLAY, staying in FF.
REQ-025 REW: step_back = beat & ~at_start; if at_start is high, state <= resume next cycle, no step issued.
REQ-026 REW: rewind_button -> state <= resume; ff_button -> FF with counter reload; play_button toggles resume as in REQ-024.
REQ-027 step_fwd and step_back SHALL never be high simultaneously and SHALL be low outside FF/REW.
REQ-028 Counter SHALL not underflow; value 0 outside FF is don't-care, never observed.

Reset
REQ-029 Reset assertion forces immediately: state PAUSE, resume PAUSE, song 0, counter 0, reset_player 0.
REQ-030 Outputs during reset: play 0, seeking 0, step_fwd 0, step_back 0.
REQ-031 Reset mid-seek SHALL abort the seek with no further strobes; events in the first cycle after deassertion are honoured normally.

Configuration
REQ-032 Macro AUTOPLAY_EN selects song_done behaviour.
REQ-033 Both builds SHALL have identical ports.
REQ-034 AUTOPLAY_EN defined: song_done in PLAY keeps state PLAY (continuous playback of next song).
REQ-035 AUTOPLAY_EN undefined: song_done in PLAY -> PAUSE.

Verification
REQ-036 Reset release, play_button pulse -> play=1 next cycle; next_button -> song 0->1, reset_player one cycle, play=0.
REQ-037 song=3, song_done in PLAY -> song=0, reset_player pulse; play stays 1 with AUTOPLAY_EN, 0 without.
REQ-038 PLAY, ff_button, 8 beats (SEEK_BEATS=8) -> exactly 8 step_fwd pulses, seeking=1 throughout, then play=1.
REQ-039 PAUSE, rewind_button, at_start rises after 3 beats -> 3 step_back pulses, then PAUSE, no further strobes.
REQ-040 Same-cycle next_button + play_button + ff_button in PLAY -> only next acted on: song+1, PAUSE, no seek.
REQ-041 Reset asserted mid-FF on a beat cycle -> no step_fwd, outputs at reset values immediately; song=0 after release.

Source files
------------

// File: rtl/transport_ctrl.sv
// Transport controller for a song player: play/pause, song select and beat-paced seeking.
// Optional macro AUTOPLAY_EN keeps PLAY across song_done; without it, song_done in PLAY pauses.
module transport_ctrl #(
    parameter int SEEK_BEATS = 8,
    parameter int CW         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_button,
    input  logic       next_button,
    input  logic       prev_button,
    input  logic       ff_button,
    input  logic       rewind_button,
    input  logic       song_done,
    input  logic       beat,
    input  logic       at_start,
    output logic       play,
    output logic       seeking,
    output logic       step_fwd,
    output logic       step_back,
    output logic [1:0] song,
    output logic       reset_player
);

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_FF    = 2'd2,
        ST_REW   = 2'd3
    } state_t;

    // resume_q: 1 = return to PLAY after a seek, 0 = return to PAUSE.
    state_t        state_q, state_d;
    logic          resume_q, resume_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    song_q, song_d;
    logic          rp_q, rp_d;

    function automatic state_t resume_state(input logic r);
        return r ? ST_PLAY : ST_PAUSE;
    endfunction

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_PAUSE;
            resume_q <= 1'b0;
            cnt_q    <= '0;
            song_q   <= 2'd0;
            rp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            cnt_q    <= cnt_d;
            song_q   <= song_d;
            rp_q     <= rp_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        resume_d  = resume_q;
        cnt_d     = cnt_q;
        song_d    = song_q;
        rp_d      = 1'b0;
        step_fwd  = 1'b0;
        step_back = 1'b0;

        if (next_button) begin
            song_d  = song_q + 2'd1;
            state_d = ST_PAUSE;
            rp_d    = 1'b1;
        end else if (prev_button) begin
            song_d  = song_q - 2'd1;
            state_d = ST_PAUSE;
            rp_d    = 1'b1;
        end else if (song_done) begin
            song_d = song_q + 2'd1;
            rp_d   = 1'b1;
            case (state_q)
`ifdef AUTOPLAY_EN
                ST_PLAY:       state_d = ST_PLAY;
`else
                ST_PLAY:       state_d = ST_PAUSE;
`endif
                ST_FF, ST_REW: state_d = resume_state(resume_q);
                default:       state_d = ST_PAUSE;
            endcase
        end else begin
            case (state_q)
                ST_PAUSE, ST_PLAY: begin
                    if (play_button) begin
                        state_d = (state_q == ST_PLAY) ? ST_PAUSE : ST_PLAY;
                    end else if (ff_button) begin
                        state_d  = ST_FF;
                        resume_d = (state_q == ST_PLAY);
                        cnt_d    = CW'(SEEK_BEATS);
                    end else if (rewind_button) begin
                        state_d  = ST_REW;
                        resume_d = (state_q == ST_PLAY);
                    end
                end
                ST_FF: begin
                    if (play_button) begin
                        resume_d = ~resume_q;
                    end else if (ff_button) begin
                        state_d = resume_state(resume_q);
                    end else if (rewind_button) begin
                        state_d = ST_REW;
                    end else if (beat) begin
                        step_fwd = 1'b1;
                        // Saturate at zero; the last beat of the burst hands control back.
                        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                        if (cnt_q <= CW'(1)) state_d = resume_state(resume_q);
                    end
                end
                ST_REW: begin
                    if (play_button) begin
                        resume_d = ~resume_q;
                    end else if (rewind_button) begin
                        state_d = resume_state(resume_q);
                    end else if (ff_button) begin
                        state_d = ST_FF;
                        cnt_d   = CW'(SEEK_BEATS);
                    end else if (at_start) begin
                        state_d = resume_state(resume_q);
                    end else if (beat) begin
                        step_back = 1'b1;
                    end
                end
                default: state_d = ST_PAUSE;
            endcase
        end
    end

    assign play         = (state_q == ST_PLAY);
    assign seeking      = (state_q == ST_FF) || (state_q == ST_REW);
    assign song         = song_q;
    assign reset_player = rp_q;

endmodule

// File: tb/tb_transport_ctrl.sv
// Scoreboard bench for transport_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_transport_ctrl;

    typedef struct packed {
        logic       play;
        logic       seeking;
        logic       step_fwd;
        logic       step_back;
        logic [1:0] song;
        logic       reset_player;
    } obs_t;

    localparam logic [7:0] I_NONE = 8'h00;
    localparam logic [7:0] I_NEXT = 8'h80;
    localparam logic [7:0] I_PREV = 8'h40;
    localparam logic [7:0] I_DONE = 8'h20;
    localparam logic [7:0] I_PLAY = 8'h10;
    localparam logic [7:0] I_FF   = 8'h08;
    localparam logic [7:0] I_REW  = 8'h04;
    localparam logic [7:0] I_BEAT = 8'h02;
    localparam logic [7:0] I_AT0  = 8'h01;

`ifdef AUTOPLAY_EN
    localparam logic AP = 1'b1;
`else
    localparam logic AP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rst_lvl = 1'b0;
    logic       play_button = 1'b0, next_button = 1'b0, prev_button = 1'b0;
    logic       ff_button = 1'b0, rewind_button = 1'b0, song_done = 1'b0;
    logic       beat = 1'b0, at_start = 1'b0;
    logic       play, seeking, step_fwd, step_back, reset_player;
    logic [1:0] song;

    obs_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_id  = 0;

    always #5 clk = ~clk;

    transport_ctrl #(.SEEK_BEATS(8), .CW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .play_button  (play_button),
        .next_button  (next_button),
        .prev_button  (prev_button),
        .ff_button    (ff_button),
        .rewind_button(rewind_button),
        .song_done    (song_done),
        .beat         (beat),
        .at_start     (at_start),
        .play         (play),
        .seeking      (seeking),
        .step_fwd     (step_fwd),
        .step_back    (step_back),
        .song         (song),
        .reset_player (reset_player)
    );

    function automatic obs_t o(input logic p, input logic s, input logic f, input logic b,
                               input logic [1:0] sg, input logic rp);
        return '{play: p, seeking: s, step_fwd: f, step_back: b, song: sg, reset_player: rp};
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue what the DUT must show.
    task automatic cyc(input logic [7:0] ev, input obs_t e);
        @(posedge clk);
        #1;
        reset         = rst_lvl;
        next_button   = ev[7];
        prev_button   = ev[6];
        song_done     = ev[5];
        play_button   = ev[4];
        ff_button     = ev[3];
        rewind_button = ev[2];
        beat          = ev[1];
        at_start      = ev[0];
        q_exp.push_back(e);
    endtask

    task automatic check(input obs_t act, input obs_t exp, input int id);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d: got play=%b seek=%b fwd=%b back=%b song=%0d rp=%b, want play=%b seek=%b fwd=%b back=%b song=%0d rp=%b",
                     id, act.play, act.seeking, act.step_fwd, act.step_back, act.song, act.reset_player,
                     exp.play, exp.seeking, exp.step_fwd, exp.step_back, exp.song, exp.reset_player);
        end
    endtask

    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            obs_t e;
            e = q_exp.pop_front();
            check('{play: play, seeking: seeking, step_fwd: step_fwd, step_back: step_back,
                    song: song, reset_player: reset_player}, e, vec_id);
            vec_id++;
        end
    end

    initial begin
        // Reset state.
        rst_lvl = 1'b0;
        cyc(I_NONE, o(0,0,0,0,0,0));
        cyc(I_PLAY, o(0,0,0,0,0,0));
        rst_lvl = 1'b1;

        // Play, then next: song 0->1, one reset_player pulse, paused.
        cyc(I_PLAY, o(0,0,0,0,0,0));
        cyc(I_NONE, o(1,0,0,0,0,0));
        cyc(I_NEXT, o(1,0,0,0,0,0));
        cyc(I_NONE, o(0,0,0,0,1,1));
        cyc(I_NONE, o(0,0,0,0,1,0));

        // Reach song 3 in PLAY, then song_done wraps to 0.
        cyc(I_NEXT, o(0,0,0,0,1,0));
        cyc(I_NEXT, o(0,0,0,0,2,1));
        cyc(I_PLAY, o(0,0,0,0,3,1));
        cyc(I_DONE, o(1,0,0,0,3,0));
        cyc(I_NONE, o(AP,0,0,0,0,1));
        if (!AP) cyc(I_PLAY, o(0,0,0,0,0,0));

        // Fast-forward from PLAY: 8 beats, one idle cycle in the middle, then back to PLAY.
        cyc(I_FF, o(1,0,0,0,0,0));
        for (int k = 0; k < 8; k++) begin
            if (k == 3) cyc(I_NONE, o(0,1,0,0,0,0));
            cyc(I_BEAT, o(0,1,1,0,0,0));
        end
        cyc(I_BEAT, o(1,0,0,0,0,0));

        // Rewind from PAUSE: 3 steps, at_start ends the seek without a step.
        cyc(I_PLAY, o(1,0,0,0,0,0));
        cyc(I_REW, o(0,0,0,0,0,0));
        for (int k = 0; k < 3; k++) cyc(I_BEAT, o(0,1,0,1,0,0));
        cyc(I_BEAT | I_AT0, o(0,1,0,0,0,0));
        cyc(I_BEAT | I_AT0, o(0,0,0,0,0,0));
        cyc(I_BEAT, o(0,0,0,0,0,0));

        // Seek buttons inside a seek: toggle resume, switch direction, cancel.
        cyc(I_FF, o(0,0,0,0,0,0));
        cyc(I_PLAY, o(0,1,0,0,0,0));
        cyc(I_REW, o(0,1,0,0,0,0));
        cyc(I_BEAT, o(0,1,0,1,0,0));
        cyc(I_FF, o(0,1,0,0,0,0));
        cyc(I_BEAT, o(0,1,1,0,0,0));
        cyc(I_FF, o(0,1,0,0,0,0));
        cyc(I_BEAT, o(1,0,0,0,0,0));

        // next + play + ff together in PLAY: only next is honoured.
        cyc(I_NEXT | I_PLAY | I_FF, o(1,0,0,0,0,0));
        cyc(I_BEAT, o(0,0,0,0,1,1));

        // prev wraps 0 -> 3.
        cyc(I_PREV, o(0,0,0,0,1,0));
        cyc(I_PREV, o(0,0,0,0,0,1));
        cyc(I_NONE, o(0,0,0,0,3,1));
        cyc(I_NONE, o(0,0,0,0,3,0));

        // Reset asserted mid-FF on a beat cycle; play honoured right after release.
        cyc(I_FF, o(0,0,0,0,3,0));
        cyc(I_BEAT, o(0,1,1,0,3,0));
        rst_lvl = 1'b0;
        cyc(I_BEAT, o(0,0,0,0,0,0));
        cyc(I_BEAT, o(0,0,0,0,0,0));
        rst_lvl = 1'b1;
        cyc(I_PLAY, o(0,0,0,0,0,0));
        cyc(I_NONE, o(1,0,0,0,0,0));

        for (int t = 0; t < 10 && q_exp.size() > 0; t++) @(posedge clk);
        if (q_exp.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule
